// File: rtl/sram_ctrl_pkg.sv
// Shared types and helpers for the SRAM controller: FSM state encoding,
// default geometry and the strobe timer width calculation.
package sram_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        DONE,
        CLEAR
    } state_t;

    localparam int DEFAULT_ADDR_WIDTH  = 16;
    localparam int DEFAULT_DATA_WIDTH  = 8;
    localparam int DEFAULT_WAIT_CYCLES = 2;

    // Timer only ever holds WAIT_CYCLES-1, so clog2(WAIT_CYCLES) bits suffice (min 1).
    function automatic int timer_width(input int wait_cycles);
        return (wait_cycles <= 2) ? 1 : $clog2(wait_cycles);
    endfunction

endpackage

// File: rtl/sram_strobe_timer.sv
// Loadable down-counter that times the SRAM strobe phase; zero flags the final cycle.
module sram_strobe_timer #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             dec,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    // Load takes priority so a fresh strobe always starts from the full count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/sram_ctrl.sv
// Synchronous front-end for an asynchronous SRAM: sequences CS_n/WE_n/OE_n with wait states.
// Define RAM_CTRL_CLEAR_EN to zero the whole array after every reset before accepting requests.
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    input  logic                  Request,
    input  logic                  Write,
    input  logic [ADDR_WIDTH-1:0] Addr,
    input  logic [DATA_WIDTH-1:0] WData,
    output logic                  Ready,
    output logic                  Ack,
    output logic [DATA_WIDTH-1:0] RData,
    output logic [ADDR_WIDTH-1:0] RamAddress,
    inout  wire  [DATA_WIDTH-1:0] RamData,
    output logic                  RamCS_n,
    output logic                  RamWE_n,
    output logic                  RamOE_n
);

    localparam int TIMER_W = timer_width(WAIT_CYCLES);
    localparam logic [TIMER_W-1:0] STROBE_RELOAD = TIMER_W'(WAIT_CYCLES - 1);

`ifdef RAM_CTRL_CLEAR_EN
    localparam state_t RESET_STATE = CLEAR;
    localparam logic   RESET_READY = 1'b0;
    logic                  clearing;
    logic [ADDR_WIDTH-1:0] clear_addr;
`else
    localparam state_t RESET_STATE = IDLE;
    localparam logic   RESET_READY = 1'b1;
    localparam logic   clearing    = 1'b0;
`endif

    state_t                state;
    logic                  is_write;
    logic                  bus_drive;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  timer_zero;

    sram_strobe_timer #(
        .WIDTH(TIMER_W)
    ) u_timer (
        .clk       (Clk),
        .rst_n     (Rst_n),
        .load      (state == SETUP),
        .load_value(STROBE_RELOAD),
        .dec       (state == STROBE),
        .zero      (timer_zero)
    );

    // Bus is only ever driven from a register, and only on write cycles.
    assign RamData = bus_drive ? wdata_q : {DATA_WIDTH{1'bz}};

    // Every SRAM-facing signal is registered here, so strobes change cleanly on Clk.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state      <= RESET_STATE;
            Ready      <= RESET_READY;
            Ack        <= 1'b0;
            RData      <= '0;
            RamAddress <= '0;
            RamCS_n    <= 1'b1;
            RamWE_n    <= 1'b1;
            RamOE_n    <= 1'b1;
            bus_drive  <= 1'b0;
            is_write   <= 1'b0;
            wdata_q    <= '0;
`ifdef RAM_CTRL_CLEAR_EN
            clearing   <= 1'b1;
            clear_addr <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (Request) begin
                        state      <= SETUP;
                        Ready      <= 1'b0;
                        RamCS_n    <= 1'b0;
                        RamAddress <= Addr;
                        is_write   <= Write;
                        wdata_q    <= WData;
                        bus_drive  <= Write;
                    end
                end
                SETUP: begin
                    state <= STROBE;
                    if (is_write) begin
                        RamWE_n <= 1'b0;
                    end else begin
                        RamOE_n <= 1'b0;
                    end
                end
                STROBE: begin
                    if (timer_zero) begin
                        state   <= DONE;
                        RamWE_n <= 1'b1;
                        RamOE_n <= 1'b1;
                        Ack     <= !clearing;
                        if (!is_write) begin
                            RData <= RamData;
                        end
                    end
                end
                DONE: begin
                    Ack       <= 1'b0;
                    RamCS_n   <= 1'b1;
                    bus_drive <= 1'b0;
`ifdef RAM_CTRL_CLEAR_EN
                    if (clearing && (clear_addr != '1)) begin
                        clear_addr <= clear_addr + 1'b1;
                        state      <= CLEAR;
                    end else begin
                        clearing <= 1'b0;
                        state    <= IDLE;
                        Ready    <= 1'b1;
                    end
`else
                    state <= IDLE;
                    Ready <= 1'b1;
`endif
                end
`ifdef RAM_CTRL_CLEAR_EN
                CLEAR: begin
                    state      <= SETUP;
                    RamCS_n    <= 1'b0;
                    RamAddress <= clear_addr;
                    is_write   <= 1'b1;
                    wdata_q    <= '0;
                    bus_drive  <= 1'b1;
                end
`endif
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_ctrl.sv
// Self-checking bench for sram_ctrl with a behavioural async SRAM hanging on the bus.
// Build with RAM_CTRL_CLEAR_EN to exercise the post-reset clear on a 16-cell array.
`timescale 1ns/1ps
module tb_sram_ctrl;

`ifdef RAM_CTRL_CLEAR_EN
    localparam int AW = 4;
`else
    localparam int AW = 16;
`endif
    localparam int DW     = 8;
    localparam int W      = 2;
    localparam int DEPTH  = 1 << AW;
    localparam int LAT    = W + 1;
    localparam int PERIOD = W + 3;

    typedef struct {
        logic        wr;
        logic [15:0] a;
        logic [7:0]  d;
        logic [7:0]  exp;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          request = 1'b0;
    logic          write = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] wdata = '0;
    logic          ready;
    logic          ack;
    logic [DW-1:0] rdata;
    logic [AW-1:0] ram_addr;
    wire  [DW-1:0] ram_data;
    logic          cs_n;
    logic          we_n;
    logic          oe_n;

    int passed = 0;
    int total = 0;
    int cyc = 0;
    int ack_cycles[$];

    sram_ctrl #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .WAIT_CYCLES(W)
    ) dut (
        .Clk       (clk),
        .Rst_n     (rst_n),
        .Request   (request),
        .Write     (write),
        .Addr      (addr),
        .WData     (wdata),
        .Ready     (ready),
        .Ack       (ack),
        .RData     (rdata),
        .RamAddress(ram_addr),
        .RamData   (ram_data),
        .RamCS_n   (cs_n),
        .RamWE_n   (we_n),
        .RamOE_n   (oe_n)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (ack) ack_cycles.push_back(cyc);
    end

    function automatic logic [DW-1:0] pattern(input int i);
        return DW'(i * 37 + 11) ^ DW'(i >> 8);
    endfunction

    // Behavioural async SRAM: drives the bus while selected and output-enabled.
    logic [DW-1:0] mem [DEPTH];
    logic          preload_en = 1'b0;
    logic          preload_ff = 1'b0;

    assign ram_data = (!cs_n && !oe_n && we_n) ? mem[ram_addr] : {DW{1'bz}};

    always @(posedge clk) begin
        if (preload_en) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= preload_ff ? {DW{1'b1}} : pattern(i);
        end else if (rst_n && !cs_n && !we_n) begin
            mem[ram_addr] <= ram_data;
        end
    end

    // Bus-level invariants, evaluated every cycle outside reset.
    logic prev_oe_n = 1'b1;
    logic prev_drive = 1'b0;
    always @(negedge clk) begin
        if (rst_n) begin
            total++;
            if (we_n | oe_n) passed++;
            else $display("[TB] FAIL strobe_overlap at cycle %0d: we_n=%0b oe_n=%0b, required one high", cyc, we_n, oe_n);
            total++;
            if (!(dut.bus_drive && (!oe_n || cs_n)) && !(dut.bus_drive && !prev_drive && !prev_oe_n)) passed++;
            else $display("[TB] FAIL bus_contention at cycle %0d: drive=%0b oe_n=%0b cs_n=%0b prev_oe_n=%0b", cyc, dut.bus_drive, oe_n, cs_n, prev_oe_n);
        end
        prev_oe_n  <= oe_n;
        prev_drive <= dut.bus_drive;
    end

    logic [DW-1:0] ref_mem [DEPTH];

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual === expected) passed++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    // Issues one access from a negedge; returns Ack latency from the accepting edge (-1 on timeout).
    task automatic apply_stimulus(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                                  output int latency, output logic [DW-1:0] got);
        int n;
        int c_req;
        n = 0;
        while (!ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        c_req   = cyc;
        request = 1'b1;
        write   = wr;
        addr    = a;
        wdata   = d;
        @(negedge clk);
        request = 1'b0;
        write   = $urandom_range(0, 1);
        wdata   = DW'($urandom);
        n = 0;
        while (!ack && n < 40) begin
            @(negedge clk);
            n++;
        end
        latency = ack ? (cyc - (c_req + 1)) : -1;
        got     = rdata;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!ready && n < 2000) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t          vecs[6];
        logic [AW-1:0] pool[8];
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [DW-1:0] got;
        logic [DW-1:0] last_rd;
        logic          wr;
        int            lat;
        int            n;
        int            c_req;
        int            v;

        vecs[0] = '{wr: 1'b1, a: 16'h0010, d: 8'hA5, exp: 8'h00};
        vecs[1] = '{wr: 1'b0, a: 16'h0010, d: 8'h00, exp: 8'hA5};
        vecs[2] = '{wr: 1'b1, a: 16'hFFFF, d: 8'h3C, exp: 8'h00};
        vecs[3] = '{wr: 1'b1, a: 16'h0000, d: 8'hC3, exp: 8'h00};
        vecs[4] = '{wr: 1'b0, a: 16'hFFFF, d: 8'h00, exp: 8'h3C};
        vecs[5] = '{wr: 1'b0, a: 16'h0000, d: 8'h00, exp: 8'hC3};

        for (int i = 0; i < DEPTH; i++) ref_mem[i] = pattern(i);
        for (int i = 0; i < 8; i++) pool[i] = AW'($urandom);

        rst_n = 1'b0;
        preload_en = 1'b1;
        preload_ff = 1'b0;
        @(negedge clk);
        preload_en = 1'b0;
        @(negedge clk);
        check_output("reset_cs_n", cs_n, 1);
        check_output("reset_we_n", we_n, 1);
        check_output("reset_oe_n", oe_n, 1);
        check_output("reset_ack", ack, 0);
        check_output("reset_rdata", rdata, 0);
        check_output("reset_ram_addr", ram_addr, 0);
        check_output("reset_bus_drive", dut.bus_drive, 0);
        rst_n = 1'b1;
`ifdef RAM_CTRL_CLEAR_EN
        check_output("reset_ready_clear", ready, 0);
        wait_ready(n);
        check_output("clear_ready_low_cycles", n, 16 * PERIOD);
        check_output("clear_no_ack", ack_cycles.size(), 0);
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
`else
        @(negedge clk);
        check_output("ready_after_release", ready, 1);
`endif

        // Directed vectors: basic write/read and the address wrap boundary.
        last_rd = '0;
        for (int k = 0; k < 6; k++) begin
            a = vecs[k].a[AW-1:0];
            apply_stimulus(vecs[k].wr, a, vecs[k].d, lat, got);
            check_output($sformatf("vec%0d_latency", k), lat, LAT);
            if (vecs[k].wr) begin
                ref_mem[a] = vecs[k].d;
                check_output($sformatf("vec%0d_rdata_hold", k), got, last_rd);
            end else begin
                check_output($sformatf("vec%0d_rdata", k), got, vecs[k].exp);
                last_rd = vecs[k].exp;
            end
            @(negedge clk);
            check_output($sformatf("vec%0d_ack_pulse", k), ack, 0);
            check_output($sformatf("vec%0d_ready_back", k), ready, 1);
        end

        // Request held high: only accepted while Ready, one access per PERIOD cycles.
        ack_cycles.delete();
        c_req   = cyc;
        request = 1'b1;
        write   = 1'b0;
        addr    = pool[0];
        repeat (2 * PERIOD + 2) @(negedge clk);
        request = 1'b0;
        repeat (2 * PERIOD) @(negedge clk);
        check_output("b2b_ack_count", ack_cycles.size(), 3);
        for (int j = 0; j < 3; j++) begin
            v = (j < ack_cycles.size()) ? ack_cycles[j] : -1;
            check_output($sformatf("b2b_ack%0d_cycle", j), v, c_req + 1 + j * PERIOD + LAT);
        end
        check_output("b2b_rdata", rdata, ref_mem[pool[0]]);
        last_rd = ref_mem[pool[0]];

        // Randomized traffic against the reference memory.
        for (int k = 0; k < 40; k++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            wr = 1'($urandom_range(0, 1));
            a  = pool[$urandom_range(0, 7)];
            d  = DW'($urandom);
            apply_stimulus(wr, a, d, lat, got);
            check_output($sformatf("rand%0d_latency", k), lat, LAT);
            if (wr) begin
                ref_mem[a] = d;
                check_output($sformatf("rand%0d_rdata_hold", k), got, last_rd);
            end else begin
                check_output($sformatf("rand%0d_rdata", k), got, ref_mem[a]);
                last_rd = ref_mem[a];
            end
            @(negedge clk);
            check_output($sformatf("rand%0d_ack_pulse", k), ack, 0);
        end

        // Reset asserted during the strobe of a write.
        while (!ready) @(negedge clk);
        a       = pool[1] ^ AW'(1);
        request = 1'b1;
        write   = 1'b1;
        addr    = a;
        wdata   = 8'h77;
        @(negedge clk);
        request = 1'b0;
        check_output("abort_setup_we_n", we_n, 1);
        check_output("abort_setup_cs_n", cs_n, 0);
        @(negedge clk);
        check_output("abort_strobe_we_n", we_n, 0);
        ack_cycles.delete();
        rst_n = 1'b0;
        #1;
        check_output("abort_we_n", we_n, 1);
        check_output("abort_oe_n", oe_n, 1);
        check_output("abort_cs_n", cs_n, 1);
        check_output("abort_bus_released", dut.bus_drive, 0);
        @(negedge clk);
        rst_n = 1'b1;
`ifdef RAM_CTRL_CLEAR_EN
        wait_ready(n);
        check_output("abort_clear_cycles", n, 16 * PERIOD);
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
`else
        @(negedge clk);
        check_output("abort_ready_after_release", ready, 1);
        ref_mem[a] = mem[a];
`endif
        repeat (PERIOD) @(negedge clk);
        check_output("abort_no_ack", ack_cycles.size(), 0);
        apply_stimulus(1'b1, a, 8'h5A, lat, got);
        @(negedge clk);
        apply_stimulus(1'b0, a, 8'h00, lat, got);
        check_output("abort_recover_latency", lat, LAT);
        check_output("abort_recover_rdata", got, 8'h5A);
        ref_mem[a] = 8'h5A;
        @(negedge clk);

`ifdef RAM_CTRL_CLEAR_EN
        // Preload all ones, reset twice (second one mid-clear), then every cell must read zero.
        preload_ff = 1'b1;
        preload_en = 1'b1;
        @(negedge clk);
        preload_en = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (23) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        ack_cycles.delete();
        rst_n = 1'b1;
        wait_ready(n);
        check_output("restart_clear_cycles", n, 16 * PERIOD);
        check_output("restart_clear_no_ack", ack_cycles.size(), 0);
        for (int i = 0; i < DEPTH; i++) begin
            apply_stimulus(1'b0, AW'(i), 8'h00, lat, got);
            check_output($sformatf("cleared_cell%0d", i), got, 8'h00);
            @(negedge clk);
        end
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
